controle_jogo: RTL
==================

// Module: controle_jogo
// PURPOSE
//  Game control unit for the LED-matrix puzzle. Debounces the eight raw push-buttons.
//  Serialises accepted presses into one-cycle button pulses for the matrix controller.
//  After each pulse, waits for the matrix win flag to settle and sequences levels
//  0..NUM_NIVEIS-1: clear matrix -> play -> advance / win / lose.
//  Sits between the board I/O and the LED-matrix controller; it drives that controller's
//  button inputs, level input and clear.
// PARAMETERS
//  DEBOUNCE_CICLOS  4   consecutive stable cycles (synchronised level) to accept a press or release; 1..255
//  NUM_NIVEIS       5   number of levels; final level index = NUM_NIVEIS-1; 1..8
//  MAX_JOGADAS      40  presses allowed per level before defeat; 1..63
// PORTS
//  clk              in   1  system clock
//  rst              in   1  synchronous, active-high reset
//  iniciar          in   1  start/restart request, level-sensitive, sampled per cycle
//  botoes_brutos    in   8  raw asynchronous button levels, 1 = pressed
//  nivel_concluido  in   1  registered win flag from the matrix controller
//  botoes_pulso     out  8  one-hot, one-cycle press pulse to the matrix controller
//  reset_matriz     out  1  one-cycle clear request to the matrix controller
//  nivel            out  3  current level index
//  jogadas          out  6  presses issued in the current level
//  jogando          out  1  high in PRONTO/PULSO/ESPERA/CHECA
//  vitoria          out  1  high in VITORIA
//  derrota          out  1  high in DERROTA
// BEHAVIOUR
//  Reset and outputs
//  - Reset (next edge, any state): state=OCIOSO; all outputs 0; sync/debounce/pending cleared.
//  - All outputs are registered.
//  Debounce
//  - Each button passes through a 2-FF synchroniser, then its own stable counter.
//  - Press accepted when the synced level has been 1 for DEBOUNCE_CICLOS consecutive edges.
//  - The button is then disarmed until its synced level has been 0 for DEBOUNCE_CICLOS edges.
//  - Accepted press sets pending[i] only while jogando=1; otherwise it is discarded.
//  - A press on a button whose pending bit is already set is ignored.
//  - Latency: raw 1 first sampled at edge e0 -> pending set at edge e0+DEBOUNCE_CICLOS+1.
//  FSM
//  - OCIOSO: iniciar=1 -> LIMPA, with nivel<=0.
//  - LIMPA (1 cycle): reset_matriz=1; jogadas<=0; pending<=0 -> ASSENTA.
//  - ASSENTA (1 cycle): lets nivel_concluido re-register on the cleared matrix -> PRONTO.
//  - PRONTO: if pending!=0, the lowest set index i is chosen -> PULSO.
//    On entry to PULSO: botoes_pulso<=1<<i; pending[i]<=0; jogadas<=jogadas+1.
//  - PULSO (pulse high this cycle only) -> ESPERA -> CHECA.
//    nivel_concluido is sampled in CHECA, the 2nd cycle after the pulse.
//  - CHECA:
//    - nivel_concluido=1 and nivel=NUM_NIVEIS-1 -> VITORIA.
//    - nivel_concluido=1 otherwise -> nivel<=nivel+1 -> LIMPA.
//    - else jogadas==MAX_JOGADAS -> DERROTA.
//    - else -> PRONTO.
//  - VITORIA / DERROTA: outputs held; iniciar=1 -> LIMPA with nivel<=0.
//  Rules and boundary conditions
//  - Minimum pulse spacing is 3 cycles (PULSO, ESPERA, CHECA); further presses stay pending.
//  - Simultaneous accepted presses: all latched; issued in ascending index order.
//  - iniciar is ignored in every state except OCIOSO, VITORIA and DERROTA.
//  - At most one bit of botoes_pulso is high; never high outside PULSO.
//  - jogadas never exceeds MAX_JOGADAS; nivel never exceeds NUM_NIVEIS-1.
//  - rst asserted mid-PULSO: botoes_pulso=0 from the next cycle.
//  - reset_matriz is not asserted by rst; the matrix controller takes rst directly.
// TESTING (DEBOUNCE_CICLOS=4, NUM_NIVEIS=5, MAX_JOGADAS=40)
//  1. rst, then iniciar=1 one cycle -> reset_matriz high exactly 1 cycle; jogando=1 two cycles later; nivel=0.
//  2. botoes_brutos[3]=1 held 20 cycles -> exactly one botoes_pulso=8'h08, 1 cycle wide,
//     6 edges after first sample; jogadas=1.
//  3. Glitch: botoes_brutos[0] high 3 cycles then low -> no pulse; jogadas=0.
//  4. Buttons 5 and 2 pressed in the same cycle -> pulse 8'h04, then 8'h20 exactly 3 cycles later; jogadas=2.
//  5. Model returns nivel_concluido=1 in CHECA at nivel=4 -> vitoria=1, jogando=0;
//     at nivel=1 -> nivel=2 and reset_matriz pulse.
//  6. 40 presses without win -> derrota=1 after 40th CHECA; further presses produce no pulses;
//     iniciar -> nivel=0, jogadas=0.

Source files
------------

// File: rtl/controle_jogo.sv
// Game control unit for the LED-matrix puzzle: debounces the eight buttons, turns
// accepted presses into one-cycle pulses and sequences levels through win or defeat.
module controle_jogo #(
   parameter int DEBOUNCE_CICLOS = 4,
   parameter int NUM_NIVEIS      = 5,
   parameter int MAX_JOGADAS     = 40
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       iniciar,
   input  logic [7:0] botoes_brutos,
   input  logic       nivel_concluido,
   output logic [7:0] botoes_pulso,
   output logic       reset_matriz,
   output logic [2:0] nivel,
   output logic [5:0] jogadas,
   output logic       jogando,
   output logic       vitoria,
   output logic       derrota
);

   localparam logic [7:0] DEB_MAX     = 8'(DEBOUNCE_CICLOS - 1);
   localparam logic [2:0] NIVEL_FINAL = 3'(NUM_NIVEIS - 1);
   localparam logic [5:0] MAX_J       = 6'(MAX_JOGADAS);

   typedef enum logic [3:0] {
      OCIOSO  = 4'd0,
      LIMPA   = 4'd1,
      ASSENTA = 4'd2,
      PRONTO  = 4'd3,
      PULSO   = 4'd4,
      ESPERA  = 4'd5,
      CHECA   = 4'd6,
      VITORIA = 4'd7,
      DERROTA = 4'd8
   } estado_t;

   estado_t         estado_r, estado_prox_s;
   logic [7:0]      sync1_r, sync2_r, pressionado_r, pendente_r;
   logic [7:0][7:0] contador_r;
   logic [7:0]      aceito_s, escolhido_s, pulso_prox_s;
   logic            emite_s;
   logic [2:0]      nivel_r, nivel_prox_s;
   logic [5:0]      jogadas_r, jogadas_prox_s;
   logic [7:0]      botoes_pulso_r;
   logic            reset_matriz_r, jogando_r, vitoria_r, derrota_r;

   // Isolates the lowest set bit, giving ascending-index service order.
   function automatic logic [7:0] menor_bit(input logic [7:0] v);
      return v & (~v + 8'd1);
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_r       <= 8'd0;
         sync2_r       <= 8'd0;
         pressionado_r <= 8'd0;
         contador_r    <= '0;
      end else begin
         sync1_r <= botoes_brutos;
         sync2_r <= sync1_r;
         // Counter tracks how long the synced level has disagreed with the debounced one.
         for (int i = 0; i < 8; i++) begin
            if (sync2_r[i] != pressionado_r[i]) begin
               if (contador_r[i] == DEB_MAX) begin
                  pressionado_r[i] <= sync2_r[i];
                  contador_r[i]    <= 8'd0;
               end else begin
                  contador_r[i] <= contador_r[i] + 8'd1;
               end
            end else begin
               contador_r[i] <= 8'd0;
            end
         end
      end
   end

   always_comb begin
      aceito_s = 8'd0;
      for (int i = 0; i < 8; i++) begin
         aceito_s[i] = sync2_r[i] & ~pressionado_r[i] & (contador_r[i] == DEB_MAX);
      end
   end

   // CHECA with pending presses goes straight to PULSO so pulses can be 3 cycles apart.
   always_comb begin
      escolhido_s = menor_bit(pendente_r);
      if (pendente_r == 8'd0) begin
         emite_s = 1'b0;
      end else if (estado_r == PRONTO) begin
         emite_s = 1'b1;
      end else if ((estado_r == CHECA) && !nivel_concluido && (jogadas_r != MAX_J)) begin
         emite_s = 1'b1;
      end else begin
         emite_s = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pendente_r <= 8'd0;
      end else if (estado_r == LIMPA) begin
         pendente_r <= 8'd0;
      end else begin
         pendente_r <= (pendente_r & ~(emite_s ? escolhido_s : 8'd0))
                     | (aceito_s & {8{jogando_r}});
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         estado_r       <= OCIOSO;
         botoes_pulso_r <= 8'd0;
         reset_matriz_r <= 1'b0;
         nivel_r        <= 3'd0;
         jogadas_r      <= 6'd0;
         jogando_r      <= 1'b0;
         vitoria_r      <= 1'b0;
         derrota_r      <= 1'b0;
      end else begin
         estado_r       <= estado_prox_s;
         botoes_pulso_r <= pulso_prox_s;
         reset_matriz_r <= (estado_prox_s == LIMPA);
         nivel_r        <= nivel_prox_s;
         jogadas_r      <= jogadas_prox_s;
         jogando_r      <= (estado_prox_s inside {PRONTO, PULSO, ESPERA, CHECA});
         vitoria_r      <= (estado_prox_s == VITORIA);
         derrota_r      <= (estado_prox_s == DERROTA);
      end
   end

   always_comb begin
      estado_prox_s = estado_r;
      case (estado_r)
         OCIOSO, VITORIA, DERROTA: begin
            if (iniciar) estado_prox_s = LIMPA;
            else         estado_prox_s = estado_r;
         end
         LIMPA:   estado_prox_s = ASSENTA;
         ASSENTA: estado_prox_s = PRONTO;
         PRONTO: begin
            if (emite_s) estado_prox_s = PULSO;
            else         estado_prox_s = PRONTO;
         end
         PULSO:   estado_prox_s = ESPERA;
         ESPERA:  estado_prox_s = CHECA;
         CHECA: begin
            if (nivel_concluido) begin
               if (nivel_r == NIVEL_FINAL) estado_prox_s = VITORIA;
               else                        estado_prox_s = LIMPA;
            end else if (jogadas_r == MAX_J) begin
               estado_prox_s = DERROTA;
            end else if (emite_s) begin
               estado_prox_s = PULSO;
            end else begin
               estado_prox_s = PRONTO;
            end
         end
         default: estado_prox_s = OCIOSO;
      endcase
   end

   always_comb begin
      pulso_prox_s   = 8'd0;
      nivel_prox_s   = nivel_r;
      jogadas_prox_s = jogadas_r;
      if (emite_s) begin
         pulso_prox_s   = escolhido_s;
         jogadas_prox_s = jogadas_r + 6'd1;
      end else begin
         pulso_prox_s = 8'd0;
      end
      case (estado_r)
         OCIOSO, VITORIA, DERROTA: begin
            if (iniciar) nivel_prox_s = 3'd0;
            else         nivel_prox_s = nivel_r;
         end
         LIMPA: jogadas_prox_s = 6'd0;
         CHECA: begin
            if (nivel_concluido && (nivel_r != NIVEL_FINAL)) nivel_prox_s = nivel_r + 3'd1;
            else                                              nivel_prox_s = nivel_r;
         end
         default: nivel_prox_s = nivel_r;
      endcase
   end

   assign botoes_pulso = botoes_pulso_r;
   assign reset_matriz = reset_matriz_r;
   assign nivel        = nivel_r;
   assign jogadas      = jogadas_r;
   assign jogando      = jogando_r;
   assign vitoria      = vitoria_r;
   assign derrota      = derrota_r;

endmodule
